// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parameterised serial sequence detector:
//   - det_state_t     : detector FSM states (FILL, ARMED)
//   - DEF_PAT_LEN     : default pattern length in bits
//   - DEF_RST_PATTERN : default pattern loaded at reset
//   - DEF_CNT_W       : default match counter width
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } det_state_t;

    localparam int         DEF_PAT_LEN     = 4;
    localparam logic [3:0] DEF_RST_PATTERN = 4'b1011;
    localparam int         DEF_CNT_W       = 8;

endpackage : seq_det_pkg

// File: rtl/seq_detector_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. It stops at all-ones and never wraps.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears count
//   inc   : increment request for this edge
//   count : current count value (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;

    // Count register: clear on reset, step on inc unless already saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector with a run-time loadable pattern, selectable
// overlapping / non-overlapping detection and a saturating match counter.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset (wins over everything)
//   x           : serial data bit
//   x_valid     : x is sampled at this edge
//   pat_in      : new pattern, MSB is the first bit received
//   pat_load    : load pat_in at this edge (wins over x_valid)
//   overlap     : 1 = overlapping detection, 0 = restart after a match
//   y           : one-cycle match pulse, one cycle after the last bit's edge
//   armed       : at least PAT_LEN valid bits held since the last clear
//   match_count : saturating number of matches
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(DEF_RST_PATTERN),
    parameter int                 CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               pat_load,
    input  logic               overlap,
    output logic               y,
    output logic               armed,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] pattern_r;
    logic [PAT_LEN-1:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    det_state_t         state_r;
    logic               y_r;
    logic               armed_r;

    logic [PAT_LEN-1:0] hist_next_s;
    logic [FILL_W-1:0]  fill_next_s;
    logic               match_s;

    // Post-shift history/fill and the match decision for the current edge.
    always_comb begin
        hist_next_s = {hist_r[PAT_LEN-2:0], x};
        // Once armed the fill count is pinned at full; in FILL it is
        // always below PAT_LEN, so the increment cannot overflow.
        if (state_r == ARMED) begin
            fill_next_s = FILL_FULL;
        end else begin
            fill_next_s = fill_r + FILL_W'(1);
        end
        match_s = x_valid && !pat_load && !rst &&
                  (hist_next_s == pattern_r) && (fill_next_s == FILL_FULL);
    end

    // Detector FSM with history, fill counter, pattern and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r <= RST_PATTERN;
            hist_r    <= {PAT_LEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            state_r   <= FILL;
            y_r       <= 1'b0;
            armed_r   <= 1'b0;
        end else if (pat_load) begin
            // A simultaneous x is deliberately dropped.
            pattern_r <= pat_in;
            hist_r    <= {PAT_LEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            state_r   <= FILL;
            y_r       <= 1'b0;
            armed_r   <= 1'b0;
        end else if (x_valid) begin
            y_r       <= match_s;
            pattern_r <= pattern_r;
            if (match_s && !overlap) begin
                // Non-overlapping: the next match needs PAT_LEN fresh bits.
                hist_r  <= {PAT_LEN{1'b0}};
                fill_r  <= {FILL_W{1'b0}};
                state_r <= FILL;
                armed_r <= 1'b0;
            end else begin
                hist_r <= hist_next_s;
                fill_r <= fill_next_s;
                case (state_r)
                    FILL: begin
                        if (fill_next_s == FILL_FULL) begin
                            state_r <= ARMED;
                            armed_r <= 1'b1;
                        end else begin
                            state_r <= FILL;
                            armed_r <= 1'b0;
                        end
                    end
                    ARMED: begin
                        state_r <= ARMED;
                        armed_r <= 1'b1;
                    end
                    default: begin
                        state_r <= FILL;
                        armed_r <= 1'b0;
                        fill_r  <= {FILL_W{1'b0}};
                    end
                endcase
            end
        end else begin
            // No valid bit: everything holds, the pulse drops.
            y_r       <= 1'b0;
            pattern_r <= pattern_r;
            hist_r    <= hist_r;
            fill_r    <= fill_r;
            state_r   <= state_r;
            armed_r   <= armed_r;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_s),
        .count (match_count)
    );

    assign y     = y_r;
    assign armed = armed_r;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param. Two instances share the stimulus:
// dut (CNT_W=8) and dut_sat (CNT_W=2, for saturation). The driver pushes the
// hand-computed expected response of every edge into a queue; the monitor
// pops one entry per cycle and compares.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       pat_load = 1'b0;
    logic       overlap = 1'b1;

    logic       y;
    logic       armed;
    logic [7:0] match_count;
    logic       y_sat;
    logic       armed_sat;
    logic [1:0] match_count_sat;

    typedef struct {
        logic y;
        logic chk;
        logic armed;
        int   cnt;
        int   cnt_sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic nxt_chk   = 1'b0;
    logic nxt_armed = 1'b0;
    int   nxt_cnt   = 0;

    seq_detector_param #(
        .PAT_LEN     (4),
        .RST_PATTERN (4'b1011),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .pat_in      (pat_in),
        .pat_load    (pat_load),
        .overlap     (overlap),
        .y           (y),
        .armed       (armed),
        .match_count (match_count)
    );

    seq_detector_param #(
        .PAT_LEN     (4),
        .RST_PATTERN (4'b1011),
        .CNT_W       (2)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .pat_in      (pat_in),
        .pat_load    (pat_load),
        .overlap     (overlap),
        .y           (y_sat),
        .armed       (armed_sat),
        .match_count (match_count_sat)
    );

    always #5 clk = ~clk;

    // Single comparison helper; only the monitor calls it.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("y", {31'd0, y}, {31'd0, mon_e.y});
            check("y_sat", {31'd0, y_sat}, {31'd0, mon_e.y});
            if (mon_e.chk) begin
                check("armed", {31'd0, armed}, {31'd0, mon_e.armed});
                check("match_count", {24'd0, match_count}, mon_e.cnt);
                check("match_count_sat", {30'd0, match_count_sat}, mon_e.cnt_sat);
            end
        end
    end

    // Arm a state check (armed, match_count) for the next step.
    task automatic ex(input logic a, input int c);
        nxt_chk   = 1'b1;
        nxt_armed = a;
        nxt_cnt   = c;
    endtask

    // Drive one clock edge worth of inputs and queue its expected response.
    task automatic step(input logic r, input logic v, input logic xb, input logic ld,
                        input logic [3:0] pin, input logic ey);
        exp_t e;
        rst      = r;
        x_valid  = v;
        x        = xb;
        pat_load = ld;
        pat_in   = pin;
        e.y       = ey;
        e.chk     = nxt_chk;
        e.armed   = nxt_armed;
        e.cnt     = nxt_cnt;
        e.cnt_sat = (nxt_cnt > 3) ? 3 : nxt_cnt;
        exp_q.push_back(e);
        nxt_chk = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic bit_in(input logic xb, input logic ey);
        step(1'b0, 1'b1, xb, 1'b0, 4'b0000, ey);
    endtask

    task automatic gap(input logic xb);
        step(1'b0, 1'b0, xb, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        ex(1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        // Reset overriding pat_load and x_valid; pattern must stay 1011.
        overlap = 1'b1;
        ex(1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        // Partial pattern 1,0,1 then reset, then a 1: no match.
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        ex(1'b0, 0);
        bit_in(1'b1, 1'b0);

        // Overlapping: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7.
        do_reset();
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b1, 1); bit_in(1'b1, 1'b1);
        overlap = 1'b0;            // not a match edge: must have no effect
        bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        overlap = 1'b1;
        ex(1'b1, 2); bit_in(1'b1, 1'b1);

        // Non-overlapping, same stream -> only the bit-4 pulse.
        do_reset();
        overlap = 1'b0;
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b0, 1); bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b0, 1); bit_in(1'b1, 1'b0);

        // Non-overlapping 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8.
        do_reset();
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b0, 1); bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b0, 2); bit_in(1'b1, 1'b1);

        // Gapped input 1,-,0,1,-,-,1 -> one pulse after the final 1.
        do_reset();
        overlap = 1'b1;
        bit_in(1'b1, 1'b0);
        ex(1'b0, 0); gap(1'b1);
        bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        gap(1'b0); gap(1'b1);
        ex(1'b1, 1); bit_in(1'b1, 1'b1);

        // pat_load 0110 with x_valid: x dropped, count kept, 0,1,1,0 matches.
        do_reset();
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b1, 1); bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0);
        ex(1'b0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b0, 1); bit_in(1'b1, 1'b0);
        ex(1'b1, 2); bit_in(1'b0, 1'b1);

        // Saturation: six overlapping matches, 2-bit counter holds at 3.
        do_reset();
        bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        ex(1'b1, 1); bit_in(1'b1, 1'b1);
        for (int k = 2; k <= 6; k++) begin
            bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
            ex(1'b1, k); bit_in(1'b1, 1'b1);
        end
        gap(1'b0);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_seq_detector_param
